// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LD  = 1'b1;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between CPU and loader; MEM_ARBITER_STARVE_EN adds a starve counter
// that forces a loader win after STARVE_MAX consecutive losses.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic cpu_req,
  input  logic ld_req,
  output logic win
);

`ifdef MEM_ARBITER_STARVE_EN
  localparam int unsigned StW = $clog2(STARVE_MAX + 1);

  logic [StW-1:0] starve_q, starve_d;
  logic           force_ld;

  assign force_ld = (starve_q == StW'(STARVE_MAX));
  assign win      = (ld_req && (!cpu_req || force_ld)) ? OWNER_LD : OWNER_CPU;

  // A loader loss is only possible below the limit, so the increment saturates by itself.
  always_comb begin
    starve_d = starve_q;
    if (idle) begin
      if (!ld_req || (win == OWNER_LD)) begin
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  localparam int unsigned unused_starve_max = STARVE_MAX;
  logic unused_pick;

  assign unused_pick = ^{clk, rst, idle};
  assign win         = (ld_req && !cpu_req) ? OWNER_LD : OWNER_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU and loader with a fixed-latency access FSM.
// Optional loader anti-starvation rule is enabled by defining MEM_ARBITER_STARVE_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              idle;
  logic              win;

  assign idle = (state_q == StIdle);

  mem_arbiter_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .cpu_req(cpu_req),
    .ld_req (ld_req),
    .win    (win)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      StIdle: begin
        if (cpu_req || ld_req) begin
          owner_d = win;
          we_d    = (win == OWNER_LD) ? ld_we    : cpu_we;
          addr_d  = (win == OWNER_LD) ? ld_addr  : cpu_addr;
          wdata_d = (win == OWNER_LD) ? ld_wdata : cpu_wdata;
          cnt_d   = CntW'(MEM_LAT - 1);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWNER_LD) ld_rdata_d  = mem_rdata;
            else                     cpu_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= OWNER_CPU;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Outputs decode straight from state so an async reset drops them immediately.
  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == StDone) && (owner_q == OWNER_CPU);
  assign ld_ack    = (state_q == StDone) && (owner_q == OWNER_LD);
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign busy      = !idle;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level reference model with its own memory image.
module tb_mem_arbiter;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_ack, ld_req, ld_we, ld_ack;
  logic [AW-1:0] cpu_addr, ld_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ld_wdata, ld_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy, owner;
  logic [DW-1:0] mem [0:4095];

  assign mem_rdata = mem[mem_addr];

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Second instance with single-cycle memory latency, memory reads a constant.
  logic          c1_req, c1_ack, l1_ack, en1, we1, busy1, owner1;
  logic [DW-1:0] c1_rdata, l1_rdata, wdata1;
  logic [AW-1:0] addr1;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)
  ) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(12'h020), .cpu_wdata(8'h00),
    .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(12'h000), .ld_wdata(8'h00),
    .ld_rdata(l1_rdata), .ld_ack(l1_ack),
    .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(8'h3C), .busy(busy1), .owner(owner1)
  );

  int n_assert;
  int n_fail;

  // Reference model: remaining busy cycles of the current access plus its latched request.
  int            m_left;
  int            m_starve;
  logic          m_owner, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic win_ld, force_ld;
    if (!rst) begin
      m_left = 0; m_starve = 0; m_owner = 1'b0; m_we = 1'b0;
      m_rdata[0] = '0; m_rdata[1] = '0;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 1) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_rdata[m_owner] = ref_mem[m_addr];
      end
    end else if (cpu_req || ld_req) begin
      force_ld = 1'b0;
`ifdef MEM_ARBITER_STARVE_EN
      force_ld = (m_starve >= int'(SMAX));
`endif
      win_ld = ld_req && (!cpu_req || force_ld);
`ifdef MEM_ARBITER_STARVE_EN
      if (!ld_req || win_ld) m_starve = 0;
      else if (m_starve < int'(SMAX)) m_starve++;
`endif
      m_owner = win_ld;
      m_we    = win_ld ? ld_we    : cpu_we;
      m_addr  = win_ld ? ld_addr  : cpu_addr;
      m_wdata = win_ld ? ld_wdata : cpu_wdata;
      m_left  = LAT + 1;
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_left > 0);
    chk("mem_en", mem_en, m_left > 1);
    chk("cpu_ack", cpu_ack, m_left == 1 && !m_owner);
    chk("ld_ack", ld_ack, m_left == 1 && m_owner);
    chk("owner", owner, m_owner);
    chk("cpu_rdata", cpu_rdata, m_rdata[0]);
    chk("ld_rdata", ld_rdata, m_rdata[1]);
    if (m_left > 1) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  // One clock: memory macro write, model update, output check; returns at the negedge.
  task automatic step();
    logic          w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    w  = mem_en && mem_we;
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clk);
    if (w) mem[wa] = wd;
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic txn(input bit ld, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int acks, output int lat);
    acks = 0;
    lat  = 0;
    if (ld) begin ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d; end
    else    begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int i = 1; i <= 12; i++) begin
      step();
      if (ld ? ld_ack : cpu_ack) begin
        acks++;
        lat = i;
        if (ld) ld_req = 1'b0;
        else    cpu_req = 1'b0;
      end else if (acks > 0 && !busy) begin
        break;
      end
    end
    ld_req  = 1'b0;
    cpu_req = 1'b0;
  endtask

  int   acks, lat, ng;
  logic got [10];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 0; ld_we  = 0; ld_addr  = '0; ld_wdata  = '0;
    c1_req  = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = DW'(i * 37 + 11);
      ref_mem[i] = mem[i];
    end
    mem[12'h010] = 8'hA5; ref_mem[12'h010] = 8'hA5;
    rst = 1'b1;
    #1 rst = 1'b0;
    model_edge();
    #12;
    check_outputs();
    chk("rst_lat1_busy", busy1, 1'b0);
    chk("rst_lat1_rdata", c1_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step();

    // CPU read of 0x010.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    step(); chk("t1_en_c1", mem_en, 1'b1);
    step(); chk("t1_en_c2", mem_en, 1'b1);
    step(); chk("t1_ack_c3", cpu_ack, 1'b1); chk("t1_rdata", cpu_rdata, 8'hA5);
    cpu_req = 0;
    step(); chk("t1_busy_c4", busy, 1'b0);

    // Loader write then CPU read-back.
    txn(1'b1, 1'b1, 12'h3FF, 8'h5C, acks, lat);
    chk("t2_ld_acks", acks, 1); chk("t2_ld_lat", lat, LAT + 1); chk("t2_owner_ld", owner, 1'b1);
    txn(1'b0, 1'b0, 12'h3FF, 8'h00, acks, lat);
    chk("t2_cpu_acks", acks, 1); chk("t2_rdata", cpu_rdata, 8'h5C); chk("t2_owner_cpu", owner, 1'b0);
    step();

    // Both requests held continuously.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h011;
    ld_req  = 1; ld_we  = 0; ld_addr  = 12'h012;
    ng = 0;
    for (int i = 0; i < 80 && ng < 10; i++) begin
      step();
      if (cpu_ack || ld_ack) begin got[ng] = ld_ack; ng++; end
    end
    cpu_req = 0; ld_req = 0;
    step(); step();
    chk("t3_grants", ng, 10);
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARBITER_STARVE_EN
      chk($sformatf("t3_grant%0d", k), got[k], (k % (SMAX + 1)) == SMAX);
`else
      chk($sformatf("t3_grant%0d", k), got[k], 1'b0);
`endif
    end

    // CPU drops req in the first ACCESS cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    step(); cpu_req = 0;
    step(); chk("t4_no_early_ack", cpu_ack, 1'b0);
    step(); chk("t4_ack", cpu_ack, 1'b1); chk("t4_rdata", cpu_rdata, 8'hA5);
    step(); chk("t4_idle", busy, 1'b0);

    // Asynchronous reset in the middle of ACCESS.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h3FF;
    step();
    #2 rst = 1'b0;
    #1;
    chk("t5_mem_en", mem_en, 1'b0); chk("t5_busy", busy, 1'b0);
    chk("t5_ack", cpu_ack, 1'b0);   chk("t5_rdata", cpu_rdata, 8'h00);
    model_edge();
    cpu_req = 0;
    step(); step();
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin step(); acks += int'(cpu_ack) + int'(ld_ack); end
    chk("t5_no_ack_after_rst", acks, 0);
    txn(1'b0, 1'b0, 12'h010, 8'h00, acks, lat);
    chk("t5_next_acks", acks, 1); chk("t5_next_lat", lat, LAT + 1);

    // MEM_LAT = 1: ack two edges after the request, then every three cycles.
    c1_req = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("t6_ack_e%0d", i), c1_ack, (i % 3) == 2);
    end
    c1_req = 0;
    chk("t6_rdata", c1_rdata, 8'h3C);
    step();

    // Random traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      step();
      if (cpu_ack) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
      end
      if (ld_ack) ld_req = 1'b0;
      else if (!ld_req && $urandom_range(0, 2) == 0) begin
        ld_req = 1'b1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = AW'($urandom_range(0, 15)); ld_wdata = DW'($urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
